adc_spi_slave_regs: RTL and testbench
=====================================

Name: adc_spi_slave_regs

Overview:
- SPI responder (slave) register file; the far end of the 16-bit ADC configuration SPI link (CPOL=0, CPHA=1, active-low CS, SCK = clk/20).
- Used as a loopback/emulation target on the test board and as the bench model for the ADC configuration path.
- Oversamples SCK/CSN/MOSI in the system clk domain. Decodes write/read frames. Holds NUM_REGS 8-bit registers. Returns read data within the same frame.

Parameters:
- NUM_REGS, 16, number of implemented registers (addresses 0..NUM_REGS-1); legal range 2..128.
- ID_VALUE, 8'hAB, read-only content of register 0x00.
- ERR_W, 8, width of the frame-error counter.

Ports:
- clk  in  1  system clock; must be at least 8x SCK.
- rst  in  1  synchronous, active-high reset.
- spi_sck  in  1  SPI clock, asynchronous to clk.
- spi_csn  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master-to-slave data.
- spi_miso  out  1  slave-to-master data.
- spi_miso_oe  out  1  tri-state enable; high while the synchronized CSN is low.
- regs_flat  out  8*NUM_REGS  all registers, reg k at bits [8k+7:8k].
- wr_strobe  out  1  one-clk pulse on each committed write.
- wr_addr  out  7  address of the last committed write.
- wr_data  out  8  data of the last committed write.
- frame_err_cnt  out  ERR_W  count of aborted or overlong frames; saturates at all-ones.

Behaviour:
- Frame format, MSB first, 16 bits: bit15 R/W (1 = read), bits14:8 address, bits7:0 data (ignored on read).
- Synchronization:
  - SCK, CSN and MOSI each pass through a 2-FF synchronizer; a third stage is used for edge detection.
  - Pin-to-internal-edge latency is 3 clk.
- Reset:
  - spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, frame_err_cnt=0.
  - Registers: reg0=ID_VALUE, all others 0. FSM goes to IDLE.
  - Reset mid-frame discards the frame, with no write and no error count.
- FSM states:
  - IDLE: CSN high. Bit counter and shift registers cleared. Go to ADDR on CSN falling edge.
  - ADDR: sample MOSI on each SCK falling edge into rx_shift. On the 8th falling edge:
    - latch R/W and address;
    - if read, load tx_shift with regs[addr] (addr>=NUM_REGS returns 8'h00);
    - go to DATA.
  - DATA: keep sampling on falling edges. The 16th falling edge goes to WAIT_CS.
  - WAIT_CS: any further SCK falling edge sets an overlong flag. On CSN rising edge go to COMMIT.
  - COMMIT (1 clk):
    - if write, exactly 16 bits received, no overlong flag, 0<addr<NUM_REGS: update the register, pulse wr_strobe, update wr_addr/wr_data;
    - writes to addr 0 or out of range are silently dropped, with no strobe and no error;
    - overlong frame increments frame_err_cnt;
    - then return to IDLE.
  - CSN rising edge in ADDR or DATA (fewer than 16 bits): abort to IDLE, increment frame_err_cnt, no write.
- MISO:
  - Updated on each SCK rising edge.
  - Rising edges 1..8 drive 0.
  - Rising edges 9..16 drive tx_shift[7], shifting left after each.
  - For write frames, tx_shift=0.
  - Holds its value between edges; forced to 0 in IDLE.
- Simultaneous events: a CSN rising edge detected in the same clk as an SCK edge takes priority and the SCK edge is ignored.
- Rising edge 9 always follows falling edge 8 by at least half an SCK period, so read data is valid before it is needed.
- The error counter saturates and never wraps.

Decomposition:
- Shared package (adc_spi_pkg): frame width 16, R/W bit index 15, address field [14:8], data field [7:0], ID register address 0, FSM state encoding.
- Natural sub-module: spi_in_sync. It is a 3-stage synchronizer plus rise/fall edge detector, instantiated for SCK and CSN; MOSI uses a plain 2-FF.

Test Plan:
- Write frame 16'h0305 -> after CSN rise: reg3=8'h05, wr_strobe high exactly 1 clk, wr_addr=3, wr_data=8'h05, frame_err_cnt=0.
- After the above, read frame 16'h8300 -> MISO bits 7..0 on rising edges 9..16 = 8'h05; MISO=0 on edges 1..8; registers unchanged.
- Read 16'h8000 -> returns ID_VALUE 8'hAB. Write 16'h0055 -> reg0 stays 8'hAB, no wr_strobe.
- Out-of-range: write 16'h2077 (NUM_REGS=16) -> no register changes, no strobe. Read 16'hA000 -> MISO 8'h00.
- Short frame of 12 clocks, then overlong frame of 17 clocks, both writing 16'h0411 -> reg4 unchanged, frame_err_cnt=2. Repeat 300 short frames with ERR_W=8 -> count saturates at 8'hFF.
- Assert rst after 10 SCK clocks of a write frame -> all outputs at reset values. A following clean write 16'h0522 sets reg5=8'h22.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared constants, frame layout and FSM encoding for the ADC configuration SPI responder.
package adc_spi_pkg;

    localparam int unsigned FRAME_W   = 16;
    localparam int unsigned ADDR_BITS = 8;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ID_ADDR   = 0;
    localparam int unsigned CNT_W     = 5;

    // bit15 R/W (1 = read), bits14:8 address, bits7:0 data
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_WAIT_CS = 3'd3;
    localparam logic [2:0] ST_COMMIT  = 3'd4;

endpackage

// File: rtl/spi_in_sync.sv
// 3-stage synchronizer with registered rise/fall pulses; pin-to-pulse latency is 3 clk.
module spi_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [2:0] stg;

    // Stages are left free-running so a reset released mid-frame sees a settled level, not a fake edge.
    always_ff @(posedge clk) begin
        stg <= {stg[1:0], pin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= stg[1] & ~stg[2];
            fall <= ~stg[1] & stg[2];
        end
    end

endmodule

// File: rtl/adc_spi_slave_regs.sv
// SPI responder register file: oversampled CPOL=0/CPHA=1 frames, 16-bit R/W + addr + data.
module adc_spi_slave_regs
    import adc_spi_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [7:0]  ID_VALUE = 8'hAB,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_csn,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic [ERR_W-1:0]      frame_err_cnt
);

    localparam int unsigned IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

    logic             sck_rise_raw, sck_fall_raw;
    logic             csn_rise, csn_fall;
    logic             sck_rise, sck_fall;
    logic [1:0]       mosi_sync;
    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] bit_cnt, rise_cnt;
    logic [FRAME_W-1:0] rx_shift, rx_next;
    logic [DATA_W-1:0]  tx_shift;
    logic             overlong;
    logic [7:0]       regs [NUM_REGS];
    logic             hdr_rw;
    logic [ADDR_W-1:0] hdr_addr;
    logic [7:0]       rd_data;
    spi_frame_t       frm;
    logic             err_inc_c, commit_c;

    spi_in_sync u_sck_sync (.clk(clk), .rst(rst), .pin(spi_sck), .rise(sck_rise_raw), .fall(sck_fall_raw));
    spi_in_sync u_csn_sync (.clk(clk), .rst(rst), .pin(spi_csn), .rise(csn_rise), .fall(csn_fall));

    always_ff @(posedge clk) begin
        mosi_sync <= {mosi_sync[0], spi_mosi};
    end

    // A CSN rise in the same clk as an SCK edge wins; the SCK edge is dropped.
    assign sck_rise = sck_rise_raw & ~csn_rise;
    assign sck_fall = sck_fall_raw & ~csn_rise;

    assign rx_next  = {rx_shift[FRAME_W-2:0], mosi_sync[1]};
    assign hdr_rw   = rx_next[DATA_W-1];
    assign hdr_addr = rx_next[ADDR_W-1:0];
    assign rd_data  = (32'(hdr_addr) < NUM_REGS) ? regs[IDX_W'(hdr_addr)] : 8'h00;
    assign frm      = spi_frame_t'(rx_shift);

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = regs[k];
    end

    always_comb begin
        state_next = state;
        err_inc_c  = 1'b0;
        commit_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (csn_fall) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (csn_rise) begin
                    state_next = ST_IDLE;
                    err_inc_c  = 1'b1;
                end else if (sck_fall && bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (csn_rise) begin
                    state_next = ST_IDLE;
                    err_inc_c  = 1'b1;
                end else if (sck_fall && bit_cnt == CNT_W'(FRAME_W - 1)) begin
                    state_next = ST_WAIT_CS;
                end
            end
            ST_WAIT_CS: begin
                if (csn_rise) state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
                if (overlong) begin
                    err_inc_c = 1'b1;
                end else if (!frm.rw && frm.addr != ADDR_W'(ID_ADDR) && 32'(frm.addr) < NUM_REGS) begin
                    commit_c = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rise_cnt      <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            overlong      <= 1'b0;
            spi_miso      <= 1'b0;
            spi_miso_oe   <= 1'b0;
            wr_strobe     <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            frame_err_cnt <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= (k == 0) ? ID_VALUE : 8'h00;
            end
        end else begin
            state     <= state_next;
            wr_strobe <= commit_c;

            // Tracks the synchronized CSN level through its edge pulses.
            if (csn_fall)      spi_miso_oe <= 1'b1;
            else if (csn_rise) spi_miso_oe <= 1'b0;

            if (commit_c) begin
                regs[IDX_W'(frm.addr)] <= frm.data;
                wr_addr                <= frm.addr;
                wr_data                <= frm.data;
            end

            if (err_inc_c && frame_err_cnt != {ERR_W{1'b1}}) begin
                frame_err_cnt <= frame_err_cnt + ERR_W'(1);
            end

            if (state == ST_IDLE) begin
                bit_cnt  <= '0;
                rise_cnt <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                overlong <= 1'b0;
                spi_miso <= 1'b0;
            end else begin
                if (sck_fall) begin
                    if (state == ST_ADDR || state == ST_DATA) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                    if (state == ST_ADDR && bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                        tx_shift <= hdr_rw ? rd_data : 8'h00;
                    end
                    if (state == ST_WAIT_CS) overlong <= 1'b1;
                end
                // Edges 1..8 drive 0, edges 9..16 shift out read data, later edges drive 0.
                if (sck_rise && state != ST_COMMIT) begin
                    if (rise_cnt < CNT_W'(FRAME_W)) rise_cnt <= rise_cnt + CNT_W'(1);
                    if (rise_cnt >= CNT_W'(ADDR_BITS) && rise_cnt < CNT_W'(FRAME_W)) begin
                        spi_miso <= tx_shift[DATA_W-1];
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end else begin
                        spi_miso <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_slave_regs.sv
// Randomized + directed bench for adc_spi_slave_regs with a queue-based scoreboard and pin-level SPI monitor.
module tb_adc_spi_slave_regs;

    localparam int unsigned NR  = 16;
    localparam logic [7:0]  IDV = 8'hAB;
    localparam int unsigned EW  = 8;
    localparam int          ERR_MAX = (1 << EW) - 1;

    logic            clk, rst;
    logic            spi_sck, spi_csn, spi_mosi;
    logic            spi_miso, spi_miso_oe;
    logic [8*NR-1:0] regs_flat;
    logic            wr_strobe;
    logic [6:0]      wr_addr;
    logic [7:0]      wr_data;
    logic [EW-1:0]   frame_err_cnt;

    adc_spi_slave_regs #(.NUM_REGS(NR), .ID_VALUE(IDV), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err_cnt(frame_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  model_regs [NR];
    int          model_err;
    logic [6:0]  model_wa;
    logic [7:0]  model_wd;
    wr_t         exp_wr_q [$];
    logic [15:0] exp_rd_q [$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8*NR-1:0] model_flat();
        logic [8*NR-1:0] f;
        for (int k = 0; k < NR; k++) f[8*k +: 8] = model_regs[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) model_regs[k] = (k == 0) ? IDV : 8'h00;
        model_err = 0;
        model_wa  = '0;
        model_wd  = '0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 128'(spi_miso), 128'(0));
        check({tag, "_oe"}, 128'(spi_miso_oe), 128'(0));
        check({tag, "_strobe"}, 128'(wr_strobe), 128'(0));
        check({tag, "_wr_addr"}, 128'(wr_addr), 128'(0));
        check({tag, "_wr_data"}, 128'(wr_data), 128'(0));
        check({tag, "_err"}, 128'(frame_err_cnt), 128'(0));
        check({tag, "_regs"}, 128'(regs_flat), 128'(model_flat()));
    endtask

    // Master: MOSI changes with SCK rising (CPHA=1); bits past 16 are random filler.
    task automatic sck_bits(input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = (i < 16) ? f[15-i] : 1'($urandom_range(0, 1));
            spi_sck  = 1'b1;
            wait_clk(10);
            spi_sck  = 1'b0;
            wait_clk(10);
        end
    endtask

    task automatic frame(input logic [15:0] f, input int n, input logic full_check);
        logic       rd;
        logic [6:0] a;
        logic [7:0] d;
        logic       in_range;
        rd = f[15];
        a  = f[14:8];
        d  = f[7:0];
        in_range = (32'(a) < NR);
        if (n >= 16 && rd) exp_rd_q.push_back({8'h00, in_range ? model_regs[a[3:0]] : 8'h00});
        if (n == 16 && !rd && a != 0 && in_range) exp_wr_q.push_back('{a: a, d: d});

        spi_csn = 1'b0;
        wait_clk(10);
        if (full_check) check("oe_in_frame", 128'(spi_miso_oe), 128'(1));
        sck_bits(f, n);
        wait_clk(10);
        spi_csn = 1'b1;
        wait_clk(12);

        if (n != 16) begin
            if (model_err < ERR_MAX) model_err++;
        end else if (!rd && a != 0 && in_range) begin
            model_regs[a[3:0]] = d;
            model_wa = a;
            model_wd = d;
        end
        if (full_check) begin
            check("regs", 128'(regs_flat), 128'(model_flat()));
            check("err_cnt", 128'(frame_err_cnt), 128'(model_err));
            check("wr_addr_hold", 128'(wr_addr), 128'(model_wa));
            check("wr_data_hold", 128'(wr_data), 128'(model_wd));
            check("oe_idle", 128'(spi_miso_oe), 128'(0));
            check("miso_idle", 128'(spi_miso), 128'(0));
        end
    endtask

    // Write scoreboard: every strobe clk must match one queued write.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_wr_strobe", 128'(wr_addr), 128'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                check("wr_addr", 128'(wr_addr), 128'(e.a));
                check("wr_data", 128'(wr_data), 128'(e.d));
            end
        end
    end

    // Pin-level SPI monitor: master samples on SCK falling edges.
    int          mon_n = 0;
    logic [15:0] mon_mosi = '0;
    logic [15:0] mon_miso = '0;

    always @(negedge spi_csn) begin
        mon_n = 0;
    end

    always @(negedge spi_sck) begin
        if (spi_csn === 1'b0) begin
            if (mon_n < 16) begin
                mon_mosi = {mon_mosi[14:0], spi_mosi};
                mon_miso = {mon_miso[14:0], spi_miso};
            end
            mon_n++;
        end
    end

    always @(posedge spi_csn) begin
        if (mon_n >= 16 && mon_mosi[15]) begin
            if (exp_rd_q.size() == 0) begin
                check("unexpected_read", 128'(mon_miso), 128'hFFFF_FFFF);
            end else begin
                check("read_miso", 128'(mon_miso), 128'(exp_rd_q.pop_front()));
            end
        end
        mon_n = 0;
    end

    initial begin
        #950000;
        failures++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; spi_csn = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        model_reset();
        wait_clk(10);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(5);

        frame(16'h0305, 16, 1'b1);
        frame(16'h8300, 16, 1'b1);
        frame(16'h8000, 16, 1'b1);
        frame(16'h0055, 16, 1'b1);
        frame(16'h2077, 16, 1'b1);
        frame(16'hA000, 16, 1'b1);
        frame(16'h0411, 12, 1'b1);
        frame(16'h0411, 17, 1'b1);
        check("err_after_short_long", 128'(frame_err_cnt), 128'(2));

        for (int i = 0; i < 300; i++) frame(16'h0411, 2, 1'b0);
        check("err_saturated", 128'(frame_err_cnt), 128'(ERR_MAX));
        check("regs_after_sat", 128'(regs_flat), 128'(model_flat()));

        // Reset in the middle of a write frame.
        spi_csn = 1'b0;
        wait_clk(10);
        sck_bits(16'h0533, 10);
        check("oe_mid_frame", 128'(spi_miso_oe), 128'(1));
        rst = 1'b1;
        wait_clk(4);
        spi_csn = 1'b1;
        wait_clk(6);
        model_reset();
        check_reset_outputs("midreset");
        rst = 1'b0;
        wait_clk(10);
        check("err_after_reset_release", 128'(frame_err_cnt), 128'(0));
        frame(16'h0522, 16, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] f;
            int          r, n;
            f[15]   = 1'($urandom_range(0, 1));
            f[14:8] = 7'($urandom_range(0, 23));
            f[7:0]  = 8'($urandom);
            r = $urandom_range(0, 9);
            n = (r < 6) ? 16 : ((r < 8) ? $urandom_range(3, 15) : $urandom_range(17, 19));
            frame(f, n, 1'b1);
        end

        wait_clk(20);
        check("wr_queue_drained", 128'(exp_wr_q.size()), 128'(0));
        check("rd_queue_drained", 128'(exp_rd_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
